// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage fed by the jump-target LUT.
//
// Registers the next instruction address and supports sequential advance,
// absolute and PC-relative jumps, stall, a start/done handshake and a
// saturating retired-instruction counter.
//
// Optional feature (macro PC_CALL_STACK_EN): a LIFO return stack of
// STACK_DEPTH entries for call_en / ret_en, with a sticky stack_err flag.
// With the macro undefined, call_en/ret_en are ignored and stack_err is 0.
//
// Ports:
//   Clk        system clock, all state updates on the rising edge
//   Reset      synchronous active-high reset
//   start      begin/restart a run from address 0 (from IDLE or HALT)
//   stall      freeze PC, state and counter for this cycle (RUN only)
//   halt_req   end-of-program; go to HALT with PC unchanged
//   abs_jump   load PC with target
//   rel_jump   add two's-complement target to PC
//   call_en    subroutine call (optional feature)
//   ret_en     subroutine return (optional feature)
//   target     D-bit jump target from the LUT
//   prog_ctr   current instruction address
//   busy       high in RUN
//   done       high in HALT
//   instr_cnt  instructions retired in the current run (saturating)
//   stack_err  sticky return-stack over/underflow flag
module pc_sequencer #(
  parameter int D           = 10,
  parameter int CNT_W       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             abs_jump,
  input  logic             rel_jump,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [D-1:0]     target,
  output logic [D-1:0]     prog_ctr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             stack_err
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_nxt;
  logic [D-1:0]     pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [D-1:0]     pc_inc;

  assign pc_inc = prog_ctr + D'(1);

`ifdef PC_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [D-1:0]    stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp, sp_nxt, sp_dec;
  logic            err_q, err_nxt;
  logic            push_en;
  logic            stack_full;

  assign sp_dec     = sp - SP_W'(1);
  assign stack_full = (sp == SP_W'(STACK_DEPTH));
  assign stack_err  = err_q;
`else
  // Call/return inputs have no function without the return stack.
  logic unused_ctrl;
  assign unused_ctrl = call_en ^ ret_en ^ (STACK_DEPTH > 0);
  assign stack_err   = 1'b0;
`endif

  // Status outputs come straight from the state register, so there is no
  // combinational path from any input.
  assign busy = (state == RUN);
  assign done = (state == HALT);

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    cnt_nxt   = instr_cnt;
`ifdef PC_CALL_STACK_EN
    sp_nxt    = sp;
    err_nxt   = err_q;
    push_en   = 1'b0;
`endif
    unique case (state)
      IDLE, HALT: begin
        // stall has no effect outside RUN.
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
`ifdef PC_CALL_STACK_EN
          sp_nxt    = '0;
          err_nxt   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!stall) begin
          // The halt_req cycle also retires an instruction.
          if (instr_cnt != '1) cnt_nxt = instr_cnt + CNT_W'(1);
          if (halt_req) begin
            state_nxt = HALT;
          end
`ifdef PC_CALL_STACK_EN
          else if (ret_en) begin
            if (sp == '0) begin
              // Underflow: behave like a plain advance and flag it.
              pc_nxt  = pc_inc;
              err_nxt = 1'b1;
            end else begin
              pc_nxt = stack_mem[sp_dec[IDX_W-1:0]];
              sp_nxt = sp_dec;
            end
          end else if (call_en) begin
            // Overflow still takes the jump; only the push is dropped.
            pc_nxt = target;
            if (stack_full) begin
              err_nxt = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_nxt  = sp + SP_W'(1);
            end
          end
`endif
          else if (abs_jump) begin
            pc_nxt = target;
          end else if (rel_jump) begin
            // Modular add handles negative (two's-complement) offsets.
            pc_nxt = prog_ctr + target;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prog_ctr  <= pc_nxt;
      instr_cnt <= cnt_nxt;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      err_q <= err_nxt;
    end
  end

  // NOTE: the stack storage is not reset; emptying it only needs sp cleared,
  // and entries above sp are never read.
  always_ff @(posedge Clk) begin
    if (!Reset && push_en) stack_mem[sp[IDX_W-1:0]] <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of {controls, expected
// outputs} vectors driven one per cycle through a scoreboard queue, followed
// by a hand-written run that drives the retired-instruction counter into
// saturation. Expectations for call/return depend on PC_CALL_STACK_EN.
module tb_pc_sequencer;

  localparam int D     = 10;
  localparam int CNT_W = 5;   // small counter so saturation is reachable

`ifdef PC_CALL_STACK_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_RST   = 8'h80;
  localparam logic [7:0] C_START = 8'h40;
  localparam logic [7:0] C_STALL = 8'h20;
  localparam logic [7:0] C_HALT  = 8'h10;
  localparam logic [7:0] C_ABS   = 8'h08;
  localparam logic [7:0] C_REL   = 8'h04;
  localparam logic [7:0] C_CALL  = 8'h02;
  localparam logic [7:0] C_RET   = 8'h01;

  typedef struct {
    logic [7:0]       ctl;
    logic [D-1:0]     tgt;
    logic [D-1:0]     pc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } vec_t;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic             abs_jump = 1'b0, rel_jump = 1'b0;
  logic             call_en = 1'b0, ret_en = 1'b0;
  logic [D-1:0]     target = '0;
  logic [D-1:0]     prog_ctr;
  logic             busy, done, stack_err;
  logic [CNT_W-1:0] instr_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  pc_sequencer #(.D(D), .CNT_W(CNT_W), .STACK_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
    .halt_req(halt_req), .abs_jump(abs_jump), .rel_jump(rel_jump),
    .call_en(call_en), .ret_en(ret_en), .target(target),
    .prog_ctr(prog_ctr), .busy(busy), .done(done),
    .instr_cnt(instr_cnt), .stack_err(stack_err)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic [7:0] ctl, input logic [D-1:0] tgt,
                              input logic [D-1:0] pc, input logic b,
                              input logic d, input int cnt, input logic e);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.pc = pc; v.busy = b; v.done = d;
    v.cnt = CNT_W'(cnt); v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic compare_next(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard at vector %0d: no expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      check("prog_ctr",  idx, 32'(prog_ctr),  32'(e.pc));
      check("busy",      idx, 32'(busy),      32'(e.busy));
      check("done",      idx, 32'(done),      32'(e.done));
      check("instr_cnt", idx, 32'(instr_cnt), 32'(e.cnt));
      check("stack_err", idx, 32'(stack_err), 32'(e.err));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge Clk);
    Reset    = v.ctl[7];
    start    = v.ctl[6];
    stall    = v.ctl[5];
    halt_req = v.ctl[4];
    abs_jump = v.ctl[3];
    rel_jump = v.ctl[2];
    call_en  = v.ctl[1];
    ret_en   = v.ctl[0];
    target   = v.tgt;
    exp_q.push_back(v);
    @(posedge Clk);
    #1;
    compare_next(idx);
  endtask

  initial begin
    // ctl, target, expected pc, busy, done, instr_cnt, stack_err
    vecs.push_back(mk(C_RST,           0,   0, 0, 0,  0, 0));
    vecs.push_back(mk(C_NONE,          0,   0, 0, 0,  0, 0));
    vecs.push_back(mk(C_STALL | C_ABS, 5,   0, 0, 0,  0, 0));  // no effect in IDLE
    vecs.push_back(mk(C_START,         0,   0, 1, 0,  0, 0));
    vecs.push_back(mk(C_NONE,          0,   1, 1, 0,  1, 0));
    vecs.push_back(mk(C_NONE,          0,   2, 1, 0,  2, 0));
    vecs.push_back(mk(C_START,         0,   3, 1, 0,  3, 0));  // start ignored in RUN
    vecs.push_back(mk(C_NONE,          0,   4, 1, 0,  4, 0));
    vecs.push_back(mk(C_REL,   10'h3FB, 1023, 1, 0,  5, 0));   // 4 + (-5)
    vecs.push_back(mk(C_NONE,          0,   0, 1, 0,  6, 0));  // wrap
    vecs.push_back(mk(C_NONE,          0,   1, 1, 0,  7, 0));
    vecs.push_back(mk(C_STALL | C_ABS, 81,  1, 1, 0,  7, 0));
    vecs.push_back(mk(C_STALL | C_ABS, 81,  1, 1, 0,  7, 0));
    vecs.push_back(mk(C_ABS,           81, 81, 1, 0,  8, 0));
    vecs.push_back(mk(C_STALL | C_HALT, 0, 81, 1, 0,  8, 0));  // halt ignored under stall
    vecs.push_back(mk(C_ABS | C_REL,  100, 100, 1, 0,  9, 0)); // abs beats rel
    vecs.push_back(mk(C_REL,           20, 120, 1, 0, 10, 0));
    vecs.push_back(mk(C_HALT | C_ABS,   7, 120, 0, 1, 11, 0)); // halt beats abs
    vecs.push_back(mk(C_NONE,           0, 120, 0, 1, 11, 0));
    vecs.push_back(mk(C_STALL | C_START, 0,  0, 1, 0,  0, 0)); // stall ignored in HALT
    vecs.push_back(mk(C_NONE,           0,   1, 1, 0,  1, 0));
    vecs.push_back(mk(C_ABS,           12,  12, 1, 0,  2, 0));
    vecs.push_back(mk(C_CALL,          45, S ? 10'd45 : 10'd13, 1, 0, 3, 0));
    vecs.push_back(mk(C_RET,            0, S ? 10'd13 : 10'd14, 1, 0, 4, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(C_CALL, 200, S ? 10'd200 : 10'(15 + i), 1, 0, 5 + i,
                        S && (i == 4)));
    vecs.push_back(mk(C_RET, 0, S ? 10'd201 : 10'd20, 1, 0, 10, S));
    vecs.push_back(mk(C_RET, 0, S ? 10'd201 : 10'd21, 1, 0, 11, S));
    vecs.push_back(mk(C_RET, 0, S ? 10'd201 : 10'd22, 1, 0, 12, S));
    vecs.push_back(mk(C_RET, 0, S ? 10'd14  : 10'd23, 1, 0, 13, S));
    vecs.push_back(mk(C_RET, 0, S ? 10'd15  : 10'd24, 1, 0, 14, S)); // underflow
    vecs.push_back(mk(C_ABS,           56,  56, 1, 0, 15, S));
    vecs.push_back(mk(C_RST | C_START | C_HALT, 0, 0, 0, 0, 0, 0)); // reset wins
    vecs.push_back(mk(C_NONE,           0,   0, 0, 0,  0, 0));  // still IDLE
    vecs.push_back(mk(C_START,          0,   0, 1, 0,  0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Counter saturation: 40 plain advances with a 5-bit counter.
    for (int i = 0; i < 40; i++)
      apply(mk(C_NONE, 0, 10'(i + 1), 1, 0, (i + 1 > 31) ? 31 : i + 1, 0),
            vecs.size() + i);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage that sits directly downstream of the jump-target lookup table. It consumes the D-bit target that the LUT produces and registers the next instruction address. Supports sequential advance, absolute and PC-relative jumps, stall, and a start/done handshake with the test harness. It also keeps a retired-instruction counter.

Parameters:
D, 10, program-counter width; equal to the LUT target width.
CNT_W, 16, width of the retired-instruction counter.
STACK_DEPTH, 4, number of return-stack entries (used only with the optional feature).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  begin or restart a program run from address 0.
stall  input  1  freeze PC, state and counter this cycle.
halt_req  input  1  decoded end-of-program instruction.
abs_jump  input  1  load PC with target.
rel_jump  input  1  add target to PC.
call_en  input  1  subroutine call (optional feature).
ret_en  input  1  subroutine return (optional feature).
target  input  D  jump target from the LUT.
prog_ctr  output  D  current instruction address.
busy  output  1  high in RUN.
done  output  1  high in HALT.
instr_cnt  output  CNT_W  number of instructions retired in the current run.
stack_err  output  1  sticky return-stack over/underflow flag.

Behaviour:
- Reset is synchronous and active-high:
  - Reset value of every output: prog_ctr=0, busy=0, done=0, instr_cnt=0, stack_err=0.
  - State returns to IDLE and the return stack is emptied.
  - Reset takes priority over all other inputs; asserting it mid-run aborts the run immediately.
- States and transitions:
  - IDLE: prog_ctr held at 0. start=1 -> RUN next cycle, with prog_ctr=0 and instr_cnt=0.
  - RUN: busy=1. One instruction retires per non-stalled cycle.
  - HALT: done=1, prog_ctr frozen. start=1 -> RUN, prog_ctr=0, instr_cnt=0, stack_err=0, stack emptied. Otherwise remain in HALT.
- RUN next-PC priority, evaluated each cycle with stall=0:
  1. halt_req -> HALT; PC unchanged.
  2. ret_en
  3. call_en
  4. abs_jump -> prog_ctr=target
  5. rel_jump -> prog_ctr=(prog_ctr+target) mod 2^D. target is two's complement, so target=all-ones means -1.
  6. otherwise -> prog_ctr+1 mod 2^D. Address 2^D-1 wraps to 0.
- Counter and stall rules:
  - instr_cnt increments on every non-stalled RUN cycle, including the halt_req cycle, and saturates at 2^CNT_W-1.
  - stall=1 in RUN freezes all registers; every other control input is ignored that cycle.
  - stall has no effect in IDLE or HALT.
  - start asserted while in RUN is ignored.
- Latency: a jump or increment is visible on prog_ctr one cycle after the controlling input is sampled. No combinational path exists from any input to any output.

Optional Feature:
Macro PC_CALL_STACK_EN.
- Defined: adds a LIFO return stack of STACK_DEPTH entries.
  - call_en pushes prog_ctr+1 (mod 2^D) and loads target.
  - ret_en pops into prog_ctr.
  - call while the stack is full: the jump is still taken, the push is dropped, and stack_err is set.
  - ret while the stack is empty: treated as prog_ctr+1, and stack_err is set.
  - stack_err is sticky until Reset or start from HALT.
- Undefined:
  - No stack storage is built.
  - call_en and ret_en are ignored; their priority slots fall through to the lower items.
  - stack_err is tied to 0.

Test Plan:
- Reset then start pulse, no controls for 5 cycles -> prog_ctr 0,1,2,3,4,5; busy=1; instr_cnt=5.
- At prog_ctr=4, rel_jump with target=10'h3FB (-5) -> prog_ctr=1023 next cycle. Following cycle with no controls -> wraps to 0.
- abs_jump with target=81 while stall=1 for 2 cycles, then stall=0 -> prog_ctr and instr_cnt frozen during the stall, prog_ctr=81 one cycle after the stall releases.
- halt_req at prog_ctr=120 -> done=1, busy=0, prog_ctr stays 120. start -> prog_ctr=0, instr_cnt=0, busy=1.
- Reset asserted mid-run at prog_ctr=56 -> next cycle prog_ctr=0, state IDLE, busy=0, done=0.
- With PC_CALL_STACK_EN: call to 45 from PC 12 -> prog_ctr=45; ret -> 13. Five calls -> stack_err=1. Ret on empty stack -> prog_ctr+1 and stack_err=1. Without the macro: same stimulus -> call_en and ret_en ignored, stack_err=0.
